// File: rtl/ysyx_23060240_seq_defs.sv
// Shared definitions for the core sequencer: state encodings, per-instruction
// flags captured at decode, and a helper classifying the bus-waiting states.
package ysyx_23060240_seq_defs;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_MEM_RD = 3'd3,
        S_MEM_WR = 3'd4,
        S_COMMIT = 3'd5,
        S_HALT   = 3'd6
    } seq_state_t;

    typedef struct packed {
        logic is_store;
    } seq_flags_t;

    // States in which the core holds a request level and waits for a done pulse.
    function automatic logic is_wait_state(input seq_state_t s);
        return (s == S_FETCH) || (s == S_MEM_RD) || (s == S_MEM_WR);
    endfunction

endpackage

// File: rtl/ysyx_23060240_core_seq_if.sv
// Handshake bundle between the core sequencer (master) and the IFU/decoder/LSU
// side (slave).
//
// Handshake: each *_req is a level, high for every cycle the core waits in the
// matching state. The paired *_done is a single-cycle pulse; the cycle in which
// done is high while its req is high completes the transfer. A done pulse seen
// while its req is low is ignored. wb_en / pc_upd are one-cycle commit strobes.
interface ysyx_23060240_core_seq_if;
    logic        ifu_done;
    logic        dec_load;
    logic        dec_store;
    logic        dec_halt;
    logic        lsu_rd_done;
    logic        lsu_wr_done;
    logic        ifu_req;
    logic        lsu_rd_req;
    logic        lsu_wr_req;
    logic        wb_en;
    logic        pc_upd;
    logic        halted;
    logic        bus_err;
    logic [31:0] instret;

    modport master (
        input  ifu_done, dec_load, dec_store, dec_halt, lsu_rd_done, lsu_wr_done,
        output ifu_req, lsu_rd_req, lsu_wr_req, wb_en, pc_upd, halted, bus_err, instret
    );

    modport slave (
        output ifu_done, dec_load, dec_store, dec_halt, lsu_rd_done, lsu_wr_done,
        input  ifu_req, lsu_rd_req, lsu_wr_req, wb_en, pc_upd, halted, bus_err, instret
    );
endinterface

// File: rtl/ysyx_23060240_seq_wdog.sv
// Transaction watchdog: counts wait cycles without a done pulse and flags a
// timeout in the cycle that would be the TIMEOUT_CYC-th one without done.
module ysyx_23060240_seq_wdog #(
    parameter int TIMEOUT_CYC = 255,
    parameter int CNT_W       = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    input  logic done,
    output logic timeout
);

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYC - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (enable && !done && !timeout) begin
            cnt <= cnt + 1'b1;
        end
    end

    // A done pulse in the final cycle suppresses the timeout.
    assign timeout = enable && !done && (cnt >= LIMIT);

endmodule

// File: rtl/ysyx_23060240_core_seq.sv
// Multi-cycle core sequencer: FETCH -> DECODE -> [MEM_RD | MEM_WR] -> COMMIT,
// with a bus watchdog, sticky halt/error and a retired-instruction counter.
module ysyx_23060240_core_seq
    import ysyx_23060240_seq_defs::*;
#(
    parameter int TIMEOUT_CYC = 255,
    parameter int CNT_W       = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    ysyx_23060240_core_seq_if.master   bus,
    output seq_state_t                 state_dbg
);

    seq_state_t  state;
    seq_flags_t  flags;
    logic        err;
    logic [31:0] instret_q;
    logic        in_wait;
    logic        wd_done;
    logic        wd_timeout;

    assign in_wait = is_wait_state(state);

    always_comb begin
        wd_done = 1'b0;
        case (state)
            S_FETCH:  wd_done = bus.ifu_done;
            S_MEM_RD: wd_done = bus.lsu_rd_done;
            S_MEM_WR: wd_done = bus.lsu_wr_done;
            default:  wd_done = 1'b0;
        endcase
    end

    // Held clear outside the wait states, so every wait starts from zero.
    ysyx_23060240_seq_wdog #(
        .TIMEOUT_CYC (TIMEOUT_CYC),
        .CNT_W       (CNT_W)
    ) u_wdog (
        .clk     (clk),
        .rst     (rst),
        .clear   (!in_wait),
        .enable  (in_wait),
        .done    (wd_done),
        .timeout (wd_timeout)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            flags     <= '0;
            err       <= 1'b0;
            instret_q <= '0;
        end else begin
            case (state)
                S_IDLE: state <= S_FETCH;
                S_FETCH: begin
                    if (bus.ifu_done) begin
                        state <= S_DECODE;
                    end else if (wd_timeout) begin
                        state <= S_HALT;
                        err   <= 1'b1;
                    end
                end
                S_DECODE: begin
                    flags.is_store <= bus.dec_store;
                    if (bus.dec_halt) begin
                        state <= S_HALT;
                    end else if (bus.dec_load && bus.dec_store) begin
                        state <= S_HALT;
                        err   <= 1'b1;
                    end else if (bus.dec_load) begin
                        state <= S_MEM_RD;
                    end else if (bus.dec_store) begin
                        state <= S_MEM_WR;
                    end else begin
                        state <= S_COMMIT;
                    end
                end
                S_MEM_RD: begin
                    if (bus.lsu_rd_done) begin
                        state <= S_COMMIT;
                    end else if (wd_timeout) begin
                        state <= S_HALT;
                        err   <= 1'b1;
                    end
                end
                S_MEM_WR: begin
                    if (bus.lsu_wr_done) begin
                        state <= S_COMMIT;
                    end else if (wd_timeout) begin
                        state <= S_HALT;
                        err   <= 1'b1;
                    end
                end
                S_COMMIT: begin
                    instret_q <= instret_q + 32'd1;
                    state     <= S_FETCH;
                end
                S_HALT:  state <= S_HALT;
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.ifu_req    = (state == S_FETCH);
    assign bus.lsu_rd_req = (state == S_MEM_RD);
    assign bus.lsu_wr_req = (state == S_MEM_WR);
    assign bus.pc_upd     = (state == S_COMMIT);
    assign bus.wb_en      = (state == S_COMMIT) && !flags.is_store;
    assign bus.halted     = (state == S_HALT);
    assign bus.bus_err    = err;
    assign bus.instret    = instret_q;
    assign state_dbg      = state;

endmodule

// File: tb/tb_ysyx_23060240_core_seq.sv
// Directed self-checking bench for the core sequencer: a default-timeout
// instance for the main flows and a TIMEOUT_CYC=4 instance for the fetch timeout.
module tb_ysyx_23060240_core_seq;
    import ysyx_23060240_seq_defs::*;

    logic clk;
    logic rst;
    seq_state_t st1;
    seq_state_t st2;

    ysyx_23060240_core_seq_if bi ();
    ysyx_23060240_core_seq_if bt ();

    ysyx_23060240_core_seq dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bi),
        .state_dbg (st1)
    );

    ysyx_23060240_core_seq #(.TIMEOUT_CYC(4), .CNT_W(16)) dut_to (
        .clk       (clk),
        .rst       (rst),
        .bus       (bt),
        .state_dbg (st2)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard ----------------
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] exp_q[$];
    logic [31:0] model_instret;
    logic        pend;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic clear_inputs();
        bi.ifu_done = 0; bi.dec_load = 0; bi.dec_store = 0; bi.dec_halt = 0;
        bi.lsu_rd_done = 0; bi.lsu_wr_done = 0;
        bt.ifu_done = 0; bt.dec_load = 0; bt.dec_store = 0; bt.dec_halt = 0;
        bt.lsu_rd_done = 0; bt.lsu_wr_done = 0;
    endtask

    // One clock; checks instret after each observed commit strobe.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
        if (pend) begin
            check("instret_after_commit", bi.instret, exp_q.pop_front());
            pend = 1'b0;
        end
        if (bi.pc_upd) begin
            model_instret = model_instret + 32'd1;
            exp_q.push_back(model_instret);
            pend = 1'b1;
        end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        clear_inputs();
        model_instret = '0;
        pend = 1'b0;
        exp_q.delete();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    // ---------------- stimulus ----------------
    int rd_cycles;
    int n_pc;
    int n_wb;
    int n_bad;
    int to_req;

    initial begin
        rst = 1'b0;
        clear_inputs();
        model_instret = '0;
        pend = 1'b0;
        @(negedge clk);
        @(negedge clk);

        // reset state
        check("rst_state", 32'(st1), 32'(S_IDLE));
        check("rst_ifu_req", 32'(bi.ifu_req), 32'd0);
        check("rst_halted", 32'(bi.halted), 32'd0);
        check("rst_bus_err", 32'(bi.bus_err), 32'd0);
        check("rst_instret", bi.instret, 32'd0);
        check("rst_strobes", {30'd0, bi.wb_en, bi.pc_upd}, 32'd0);

        rst = 1'b1;
        check("idle_after_release", 32'(bi.ifu_req), 32'd0);

        // fetch timeout on the TIMEOUT_CYC=4 instance; main instance waits in FETCH
        to_req = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (bt.ifu_req) to_req++;
            if (i == 0) check("first_fetch_req", 32'(bi.ifu_req), 32'd1);
            if (i == 2) bi.lsu_rd_done = 1'b1;
            if (i == 3) begin
                bi.lsu_rd_done = 1'b0;
                check("stray_done_ignored", 32'(st1), 32'(S_FETCH));
            end
        end
        check("to_fetch_cycles", 32'(to_req), 32'd4);
        check("to_bus_err", 32'(bt.bus_err), 32'd1);
        check("to_halted", 32'(bt.halted), 32'd1);
        check("to_ifu_req_low", 32'(bt.ifu_req), 32'd0);

        // ALU stream: ifu_done held high for 30 cycles
        bi.ifu_done = 1'b1;
        n_pc = 0; n_wb = 0; n_bad = 0;
        for (int k = 1; k <= 30; k++) begin
            step();
            if (bi.pc_upd) n_pc++;
            if (bi.wb_en) n_wb++;
            if (bi.pc_upd != ((k % 3) == 2)) n_bad++;
        end
        bi.ifu_done = 1'b0;
        check("alu_pc_upd_count", 32'(n_pc), 32'd10);
        check("alu_wb_en_count", 32'(n_wb), 32'd10);
        check("alu_strobe_phase", 32'(n_bad), 32'd0);
        check("alu_instret", bi.instret, 32'd10);

        // load with lsu_rd_done after 5 waiting cycles
        bi.ifu_done = 1'b1; bi.dec_load = 1'b1;
        step();
        bi.ifu_done = 1'b0;
        step();
        rd_cycles = 0;
        for (int i = 0; i < 20 && bi.lsu_rd_req; i++) begin
            rd_cycles++;
            bi.lsu_rd_done = (rd_cycles == 6);
            step();
        end
        bi.lsu_rd_done = 1'b0; bi.dec_load = 1'b0;
        check("load_req_cycles", 32'(rd_cycles), 32'd6);
        check("load_commit", {29'd0, bi.lsu_rd_req, bi.wb_en, bi.pc_upd}, 32'b011);
        step();
        check("load_strobe_one_cycle", {30'd0, bi.wb_en, bi.pc_upd}, 32'd0);

        // store
        bi.ifu_done = 1'b1; bi.dec_store = 1'b1;
        step();
        bi.ifu_done = 1'b0;
        step();
        check("store_wr_req", 32'(bi.lsu_wr_req), 32'd1);
        bi.lsu_wr_done = 1'b1;
        step();
        bi.lsu_wr_done = 1'b0; bi.dec_store = 1'b0;
        check("store_commit", {30'd0, bi.wb_en, bi.pc_upd}, 32'b01);
        step();
        check("store_instret", bi.instret, 32'd12);

        // done arriving in the same cycle as the 255th wait cycle wins
        for (int i = 0; i < 254; i++) step();
        check("wd_still_fetch", 32'(st1), 32'(S_FETCH));
        bi.ifu_done = 1'b1;
        step();
        bi.ifu_done = 1'b0;
        check("wd_done_wins", 32'(st1), 32'(S_DECODE));
        check("wd_no_err", 32'(bi.bus_err), 32'd0);
        step();
        step();

        // illegal decode: load and store together
        bi.ifu_done = 1'b1; bi.dec_load = 1'b1; bi.dec_store = 1'b1;
        step();
        bi.ifu_done = 1'b0;
        step();
        bi.dec_load = 1'b0; bi.dec_store = 1'b0;
        check("illegal_halted", 32'(bi.halted), 32'd1);
        check("illegal_bus_err", 32'(bi.bus_err), 32'd1);
        step();
        step();
        check("halt_quiet", {27'd0, bi.ifu_req, bi.lsu_rd_req, bi.lsu_wr_req, bi.wb_en, bi.pc_upd}, 32'd0);
        check("halt_sticky", 32'(st1), 32'(S_HALT));

        // ebreak takes priority over a load
        do_reset();
        step();
        bi.ifu_done = 1'b1; bi.dec_halt = 1'b1; bi.dec_load = 1'b1;
        step();
        bi.ifu_done = 1'b0;
        step();
        bi.dec_halt = 1'b0; bi.dec_load = 1'b0;
        check("ebreak_halted", 32'(bi.halted), 32'd1);
        check("ebreak_no_err", 32'(bi.bus_err), 32'd0);
        check("ebreak_instret", bi.instret, 32'd0);

        // reset in the middle of a store, after one retired instruction
        do_reset();
        step();
        bi.ifu_done = 1'b1;
        step(); step(); step();
        bi.dec_store = 1'b1;
        step();
        bi.ifu_done = 1'b0;
        step();
        bi.dec_store = 1'b0;
        check("mid_wr_req", 32'(bi.lsu_wr_req), 32'd1);
        check("mid_instret", bi.instret, 32'd1);
        rst = 1'b0;
        #1;
        check("rst_async_wr_req", 32'(bi.lsu_wr_req), 32'd0);
        check("rst_async_instret", bi.instret, 32'd0);
        check("rst_async_state", 32'(st1), 32'(S_IDLE));
        pend = 1'b0;
        exp_q.delete();
        model_instret = '0;
        @(negedge clk);
        rst = 1'b1;
        check("rerelease_idle", 32'(bi.ifu_req), 32'd0);
        step();
        check("rerelease_fetch", 32'(bi.ifu_req), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Hard time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "time limit");
    end

endmodule
